// File: rtl/dll_fc_init.sv
// Data-link flow-control initialisation for VC0.
// Sends InitFC1/InitFC2 P/NP/Cpl sets, resends them after an idle gap and
// records the remote credits advertised by the link partner.
module dll_fc_init #(
  parameter int unsigned RESEND_CYCLES = 1024
) (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic [1:0]  dlcm_state_i,
  input  logic [23:0] adv_hdrfc_i,
  input  logic [35:0] adv_datafc_i,
  output logic        dllp_valid_o,
  output logic [31:0] dllp_o,
  input  logic        dllp_ready_i,
  input  logic        rx_dllp_valid_i,
  input  logic [31:0] rx_dllp_i,
  output logic        init1_end_o,
  output logic        init2_end_o,
  output logic [23:0] rmt_hdrfc_o,
  output logic [35:0] rmt_datafc_o,
  output logic        rmt_fc_valid_o
);

  localparam logic [1:0]  DlcmInactive = 2'd0;
  localparam logic [1:0]  DlcmInit1    = 2'd1;
  localparam logic [1:0]  DlcmInit2    = 2'd2;
  localparam logic [1:0]  IdxP         = 2'd0;
  localparam logic [1:0]  IdxCpl       = 2'd2;
  localparam logic [7:0]  TypeInitFc1  = 8'h40;
  localparam logic [7:0]  TypeInitFc2  = 8'hC0;
  localparam logic [15:0] ResendLast   = 16'(RESEND_CYCLES - 1);
  localparam logic [15:0] TimerMax     = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StF1Send,
    StF1Wait,
    StF1Done,
    StF2Send,
    StF2Wait,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [31:0] dllp_q, dllp_d;
  logic [15:0] timer_q, timer_d;
  logic        init1_end_q, init1_end_d;
  logic        init2_end_q, init2_end_d;
  logic [2:0]  recv_q, recv_d;
  logic        fi2_q, fi2_d;
  logic [23:0] rmt_hdr_q, rmt_hdr_d;
  logic [35:0] rmt_data_q, rmt_data_d;

  logic [7:0]  rx_type;
  logic [1:0]  rx_t;
  logic        rx_is_init1, rx_is_init2, rx_is_update;
  logic [2:0]  rx_onehot;
  logic        rx_new;
  logic        in_f1, in_f2;
  logic        phase2, xfer, fi1_now, set_done;
  logic [7:0]  set_base;
  state_e      send_st, wait_st, end_st;

  // Builds one InitFC DLLP of the set; idx selects P/NP/Cpl and the type offset.
  function automatic logic [31:0] fc_word(input logic [7:0]  base,
                                          input logic [1:0]  idx,
                                          input logic [23:0] hdr,
                                          input logic [35:0] data);
    logic [7:0]  ty;
    logic [7:0]  h;
    logic [11:0] d;
    ty = base + {2'b00, idx, 4'h0};
    case (idx)
      2'd0:    begin h = hdr[7:0];   d = data[11:0];  end
      2'd1:    begin h = hdr[15:8];  d = data[23:12]; end
      default: begin h = hdr[23:16]; d = data[35:24]; end
    endcase
    return {ty, 2'b00, h, 2'b00, d};
  endfunction

  // Received DLLP classification; exact type bytes only, so non-VC0 never matches.
  always_comb begin
    rx_type      = rx_dllp_i[31:24];
    rx_t         = rx_type[5:4];
    rx_is_init1  = rx_dllp_valid_i && rx_type[7:6] == 2'b01 && rx_type[3:0] == 4'h0 &&
                   rx_t != 2'b11;
    rx_is_init2  = rx_dllp_valid_i && rx_type[7:6] == 2'b11 && rx_type[3:0] == 4'h0 &&
                   rx_t != 2'b11;
    rx_is_update = rx_dllp_valid_i && rx_type[7:6] == 2'b10 && rx_type[3:0] == 4'h0 &&
                   rx_t != 2'b11;
    case (rx_t)
      2'd0:    rx_onehot = 3'b001;
      2'd1:    rx_onehot = 3'b010;
      2'd2:    rx_onehot = 3'b100;
      default: rx_onehot = 3'b000;
    endcase
    in_f1  = state_q == StF1Send || state_q == StF1Wait || state_q == StF1Done;
    in_f2  = state_q == StF2Send || state_q == StF2Wait;
    rx_new = in_f1 && (rx_is_init1 || rx_is_init2) && ((rx_onehot & ~recv_q) != 3'b000);
  end

  // Remote credit capture: first InitFC of each type wins, later copies are dropped.
  always_comb begin
    recv_d     = recv_q;
    rmt_hdr_d  = rmt_hdr_q;
    rmt_data_d = rmt_data_q;
    fi2_d      = fi2_q | (in_f2 && (rx_is_init2 || rx_is_update));
    if (rx_new) begin
      recv_d = recv_q | rx_onehot;
      case (rx_t)
        2'd0: begin
          rmt_hdr_d[7:0]   = rx_dllp_i[21:14];
          rmt_data_d[11:0] = rx_dllp_i[11:0];
        end
        2'd1: begin
          rmt_hdr_d[15:8]   = rx_dllp_i[21:14];
          rmt_data_d[23:12] = rx_dllp_i[11:0];
        end
        default: begin
          rmt_hdr_d[23:16]  = rx_dllp_i[21:14];
          rmt_data_d[35:24] = rx_dllp_i[11:0];
        end
      endcase
    end
    if (dlcm_state_i == DlcmInactive) begin
      recv_d     = 3'b000;
      fi2_d      = 1'b0;
      rmt_hdr_d  = '0;
      rmt_data_d = '0;
    end
  end

  // FSM next state, transmit handshake and resend timer.
  always_comb begin
    phase2   = state_q == StF2Send || state_q == StF2Wait;
    set_base = phase2 ? TypeInitFc2 : TypeInitFc1;
    send_st  = phase2 ? StF2Send : StF1Send;
    wait_st  = phase2 ? StF2Wait : StF1Wait;
    end_st   = phase2 ? StDone : StF1Done;
    xfer     = valid_q && dllp_ready_i;
    // Receipt in this very cycle counts toward completion at a set boundary.
    fi1_now  = &recv_d;
    set_done = phase2 ? fi2_d : fi1_now;

    state_d     = state_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    dllp_d      = dllp_q;
    timer_d     = timer_q;
    init1_end_d = 1'b0;
    init2_end_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dlcm_state_i == DlcmInit1) begin
          state_d = StF1Send;
          idx_d   = IdxP;
          valid_d = 1'b1;
          dllp_d  = fc_word(TypeInitFc1, IdxP, adv_hdrfc_i, adv_datafc_i);
        end
      end
      StF1Send, StF2Send: begin
        if (xfer) begin
          if (idx_q != IdxCpl) begin
            idx_d  = idx_q + 2'd1;
            dllp_d = fc_word(set_base, idx_q + 2'd1, adv_hdrfc_i, adv_datafc_i);
          end else begin
            valid_d = 1'b0;
            idx_d   = IdxP;
            timer_d = '0;
            if (set_done) begin
              state_d     = end_st;
              init1_end_d = ~phase2;
              init2_end_d = phase2;
            end else begin
              state_d = wait_st;
            end
          end
        end
      end
      StF1Wait, StF2Wait: begin
        if (set_done) begin
          state_d     = end_st;
          init1_end_d = ~phase2;
          init2_end_d = phase2;
        end else if (timer_q == ResendLast) begin
          state_d = send_st;
          idx_d   = IdxP;
          valid_d = 1'b1;
          dllp_d  = fc_word(set_base, IdxP, adv_hdrfc_i, adv_datafc_i);
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + 16'd1;
        end
      end
      StF1Done: begin
        if (dlcm_state_i == DlcmInit2) begin
          state_d = StF2Send;
          idx_d   = IdxP;
          valid_d = 1'b1;
          dllp_d  = fc_word(TypeInitFc2, IdxP, adv_hdrfc_i, adv_datafc_i);
        end
      end
      StDone: valid_d = 1'b0;
      default: state_d = StIdle;
    endcase

    // Link going inactive aborts everything, including an offer mid-handshake.
    if (dlcm_state_i == DlcmInactive) begin
      state_d     = StIdle;
      idx_d       = IdxP;
      valid_d     = 1'b0;
      dllp_d      = '0;
      timer_d     = '0;
      init1_end_d = 1'b0;
      init2_end_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= StIdle;
      idx_q       <= IdxP;
      valid_q     <= 1'b0;
      dllp_q      <= '0;
      timer_q     <= '0;
      init1_end_q <= 1'b0;
      init2_end_q <= 1'b0;
      recv_q      <= 3'b000;
      fi2_q       <= 1'b0;
      rmt_hdr_q   <= '0;
      rmt_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      dllp_q      <= dllp_d;
      timer_q     <= timer_d;
      init1_end_q <= init1_end_d;
      init2_end_q <= init2_end_d;
      recv_q      <= recv_d;
      fi2_q       <= fi2_d;
      rmt_hdr_q   <= rmt_hdr_d;
      rmt_data_q  <= rmt_data_d;
    end
  end

  assign dllp_valid_o   = valid_q;
  assign dllp_o         = dllp_q;
  assign init1_end_o    = init1_end_q;
  assign init2_end_o    = init2_end_q;
  assign rmt_hdrfc_o    = rmt_hdr_q;
  assign rmt_datafc_o   = rmt_data_q;
  assign rmt_fc_valid_o = &recv_q;

endmodule

// File: tb/tb_dll_fc_init.sv
// Bench for dll_fc_init: credit-pattern table plus hand-written handshake,
// resend, receive, FC_INIT2 and link-drop sequences; transfers are checked
// against a queue of expected DLLP words.
module tb_dll_fc_init;

  logic        sclk;
  logic        srst_n;
  logic [1:0]  dlcm_state_i;
  logic [23:0] adv_hdrfc_i;
  logic [35:0] adv_datafc_i;
  logic        dllp_valid_o;
  logic [31:0] dllp_o;
  logic        dllp_ready_i;
  logic        rx_dllp_valid_i;
  logic [31:0] rx_dllp_i;
  logic        init1_end_o;
  logic        init2_end_o;
  logic [23:0] rmt_hdrfc_o;
  logic [35:0] rmt_datafc_o;
  logic        rmt_fc_valid_o;

  dll_fc_init #(
    .RESEND_CYCLES(8)
  ) dut (
    .sclk            (sclk),
    .srst_n          (srst_n),
    .dlcm_state_i    (dlcm_state_i),
    .adv_hdrfc_i     (adv_hdrfc_i),
    .adv_datafc_i    (adv_datafc_i),
    .dllp_valid_o    (dllp_valid_o),
    .dllp_o          (dllp_o),
    .dllp_ready_i    (dllp_ready_i),
    .rx_dllp_valid_i (rx_dllp_valid_i),
    .rx_dllp_i       (rx_dllp_i),
    .init1_end_o     (init1_end_o),
    .init2_end_o     (init2_end_o),
    .rmt_hdrfc_o     (rmt_hdrfc_o),
    .rmt_datafc_o    (rmt_datafc_o),
    .rmt_fc_valid_o  (rmt_fc_valid_o)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic [23:0] hdr;
    logic [35:0] data;
    logic [31:0] exp_p;
    logic [31:0] exp_np;
    logic [31:0] exp_cpl;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] sb [$];
  int          xfer_t [$];
  int          offer_t [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          n_init1 = 0;
  int          n_init2 = 0;
  int          init1_t = 0;
  int          init2_t = 0;
  int          t0 = 0;
  logic        valid_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] ty, input logic [7:0] h,
                                     input logic [11:0] d);
    return {ty, 2'b00, h, 2'b00, d};
  endfunction

  // Sample on the falling edge (values the next rising edge will use), then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic cyc();
    logic [31:0] e;
    @(negedge sclk);
    cyc_n++;
    if (dllp_valid_o && !valid_prev) offer_t.push_back(cyc_n);
    valid_prev = dllp_valid_o;
    if (init1_end_o) begin n_init1++; init1_t = cyc_n; end
    if (init2_end_o) begin n_init2++; init2_t = cyc_n; end
    if (dllp_valid_o && dllp_ready_i) begin
      xfer_t.push_back(cyc_n);
      if (sb.size() == 0) begin
        check("xfer_unexpected", 64'(dllp_o), 64'h0);
      end else begin
        e = sb.pop_front();
        check("xfer_word", 64'(dllp_o), 64'(e));
      end
    end
    @(posedge sclk);
    #1;
  endtask

  task automatic rx_one(input logic [31:0] w);
    rx_dllp_valid_i = 1'b1;
    rx_dllp_i       = w;
    cyc();
    rx_dllp_valid_i = 1'b0;
    rx_dllp_i       = '0;
  endtask

  task automatic wait_type(input logic [7:0] ty, input int max, input string name);
    int i;
    i = 0;
    while (!(dllp_valid_o && dllp_o[31:24] == ty) && i < max) begin
      cyc();
      i++;
    end
    check(name, 64'(dllp_valid_o && dllp_o[31:24] == ty), 64'd1);
  endtask

  task automatic do_reset();
    srst_n          = 1'b0;
    dlcm_state_i    = 2'd0;
    dllp_ready_i    = 1'b0;
    rx_dllp_valid_i = 1'b0;
    rx_dllp_i       = '0;
    cyc();
    srst_n = 1'b1;
    sb.delete();
    xfer_t.delete();
    offer_t.delete();
    n_init1    = 0;
    n_init2    = 0;
    init1_t    = 0;
    init2_t    = 0;
    valid_prev = 1'b0;
  endtask

  initial begin
    vecs[0] = '{24'h030220, 36'h003002080, 32'h40080080, 32'h50008002, 32'h6000C003};
    vecs[1] = '{24'hFFFFFF, 36'hFFFFFFFFF, 32'h403FCFFF, 32'h503FCFFF, 32'h603FCFFF};
    vecs[2] = '{24'h000000, 36'h000000000, 32'h40000000, 32'h50000000, 32'h60000000};
    vecs[3] = '{24'hA55A01, 36'h800555001, 32'h40004001, 32'h50168555, 32'h60294800};

    // Reset state, with INIT1 requested while reset is held.
    srst_n          = 1'b0;
    dlcm_state_i    = 2'd1;
    adv_hdrfc_i     = vecs[0].hdr;
    adv_datafc_i    = vecs[0].data;
    dllp_ready_i    = 1'b0;
    rx_dllp_valid_i = 1'b0;
    rx_dllp_i       = '0;
    cyc();
    cyc();
    check("rst_valid", 64'(dllp_valid_o), 64'd0);
    check("rst_dllp", 64'(dllp_o), 64'd0);
    check("rst_init1", 64'(init1_end_o), 64'd0);
    check("rst_init2", 64'(init2_end_o), 64'd0);
    check("rst_rmt_hdr", 64'(rmt_hdrfc_o), 64'd0);
    check("rst_rmt_data", 64'(rmt_datafc_o), 64'd0);
    check("rst_fc_valid", 64'(rmt_fc_valid_o), 64'd0);
    srst_n       = 1'b1;
    dlcm_state_i = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_inactive_quiet", 64'(dllp_valid_o), 64'd0);
    end
    dlcm_state_i = 2'd2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_init2_quiet", 64'(dllp_valid_o), 64'd0);
    end

    // Credit patterns: one InitFC1 set, back-to-back with ready held high.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      adv_hdrfc_i  = vecs[r].hdr;
      adv_datafc_i = vecs[r].data;
      sb.push_back(vecs[r].exp_p);
      sb.push_back(vecs[r].exp_np);
      sb.push_back(vecs[r].exp_cpl);
      dllp_ready_i = 1'b1;
      dlcm_state_i = 2'd1;
      t0 = cyc_n + 1;
      for (int i = 0; i < 10 && xfer_t.size() < 3; i++) cyc();
      check("tbl_nxfer", 64'(xfer_t.size()), 64'd3);
      if (xfer_t.size() == 3) begin
        check("tbl_first_lat", 64'(xfer_t[0] - t0), 64'd1);
        check("tbl_back2back", 64'(xfer_t[2] - xfer_t[0]), 64'd2);
      end
      check("tbl_sb_empty", 64'(sb.size()), 64'd0);
    end

    // Stall the P offer for 5 cycles, then let three sets go with resends.
    do_reset();
    adv_hdrfc_i  = vecs[0].hdr;
    adv_datafc_i = vecs[0].data;
    for (int s = 0; s < 3; s++) begin
      sb.push_back(vecs[0].exp_p);
      sb.push_back(vecs[0].exp_np);
      sb.push_back(vecs[0].exp_cpl);
    end
    dlcm_state_i = 2'd1;
    wait_type(8'h40, 4, "stall_offer");
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {31'd0, dllp_valid_o, dllp_o}, {31'd0, 1'b1, 32'h40080080});
      cyc();
    end
    dllp_ready_i = 1'b1;
    for (int i = 0; i < 60 && xfer_t.size() < 9; i++) cyc();
    check("resend_nxfer", 64'(xfer_t.size()), 64'd9);
    if (xfer_t.size() == 9 && offer_t.size() >= 3) begin
      check("stall_xfer_6th", 64'(xfer_t[0] - offer_t[0]), 64'd5);
      check("resend_gap1", 64'(offer_t[1] - xfer_t[2] - 1), 64'd8);
      check("resend_gap2", 64'(offer_t[2] - xfer_t[5] - 1), 64'd8);
    end
    check("resend_no_init1", 64'(n_init1), 64'd0);

    // Receive InitFC1 while NP is held; duplicate NP and foreign types ignored.
    do_reset();
    adv_hdrfc_i  = vecs[0].hdr;
    adv_datafc_i = vecs[0].data;
    sb.push_back(vecs[0].exp_p);
    sb.push_back(vecs[0].exp_np);
    sb.push_back(vecs[0].exp_cpl);
    dllp_ready_i = 1'b1;
    dlcm_state_i = 2'd1;
    wait_type(8'h50, 5, "rx_np_offer");
    dllp_ready_i = 1'b0;
    rx_one(mk(8'h41, 8'h77, 12'h777));
    rx_one(mk(8'h80, 8'h66, 12'h666));
    rx_one(mk(8'h40, 8'h11, 12'h111));
    rx_one(mk(8'h50, 8'h10, 12'h010));
    check("rx_partial_fc_valid", 64'(rmt_fc_valid_o), 64'd0);
    rx_one(mk(8'h50, 8'h30, 12'h030));
    rx_one(mk(8'h60, 8'h22, 12'h222));
    check("rx_fc_valid", 64'(rmt_fc_valid_o), 64'd1);
    check("rx_rmt_hdr", 64'(rmt_hdrfc_o), 64'h221011);
    check("rx_rmt_data", 64'(rmt_datafc_o), 64'h222010111);
    check("rx_np_still_held", {31'd0, dllp_valid_o, dllp_o}, {31'd0, 1'b1, 32'h50008002});
    check("rx_no_early_init1", 64'(n_init1), 64'd0);
    dllp_ready_i = 1'b1;
    for (int i = 0; i < 8 && n_init1 == 0; i++) cyc();
    check("init1_pulse", 64'(n_init1), 64'd1);
    if (xfer_t.size() == 3) check("init1_after_cpl", 64'(init1_t - xfer_t[2]), 64'd1);
    repeat (12) cyc();
    check("init1_single", 64'(n_init1), 64'd1);
    check("f1done_no_resend", 64'(offer_t.size()), 64'd1);
    check("f1done_quiet", 64'(dllp_valid_o), 64'd0);
    check("f1_sb_empty", 64'(sb.size()), 64'd0);

    // FC_INIT2: InitFC1 ignored, UpdateFC on the Cpl transfer cycle completes.
    for (int s = 0; s < 2; s++) begin
      sb.push_back(32'hC0080080);
      sb.push_back(32'hD0008002);
      sb.push_back(32'hE000C003);
    end
    dlcm_state_i = 2'd2;
    wait_type(8'hC0, 4, "f2_p_offer");
    rx_one(mk(8'h40, 8'h99, 12'h999));
    wait_type(8'hE0, 4, "f2_cpl1_offer");
    cyc();
    cyc();
    check("f2_initfc1_ignored", 64'(n_init2), 64'd0);
    wait_type(8'hE0, 20, "f2_cpl2_offer");
    rx_one(mk(8'h80, 8'h01, 12'h001));
    cyc();
    check("init2_pulse", 64'(n_init2), 64'd1);
    if (xfer_t.size() > 0) check("init2_after_cpl", 64'(init2_t - xfer_t[xfer_t.size() - 1]),
                                 64'd1);
    check("f2_sb_empty", 64'(sb.size()), 64'd0);
    dlcm_state_i = 2'd3;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("done_quiet", 64'(dllp_valid_o), 64'd0);
    end
    check("init2_single", 64'(n_init2), 64'd1);
    check("done_rmt_hdr_frozen", 64'(rmt_hdrfc_o), 64'h221011);
    check("done_rmt_data_frozen", 64'(rmt_datafc_o), 64'h222010111);

    // Link drops mid-handshake; state must be fully cleared for the retry.
    do_reset();
    adv_hdrfc_i  = vecs[0].hdr;
    adv_datafc_i = vecs[0].data;
    dlcm_state_i = 2'd1;
    wait_type(8'h40, 4, "drop_offer");
    rx_one(mk(8'h40, 8'h55, 12'h555));
    check("drop_pre_hdr", 64'(rmt_hdrfc_o), 64'h000055);
    check("drop_pre_data", 64'(rmt_datafc_o), 64'h000000555);
    dlcm_state_i = 2'd0;
    cyc();
    check("drop_valid", 64'(dllp_valid_o), 64'd0);
    check("drop_rmt_hdr", 64'(rmt_hdrfc_o), 64'd0);
    check("drop_rmt_data", 64'(rmt_datafc_o), 64'd0);
    check("drop_fc_valid", 64'(rmt_fc_valid_o), 64'd0);
    dlcm_state_i = 2'd1;
    wait_type(8'h40, 4, "drop_reoffer");
    rx_one(mk(8'h40, 8'h66, 12'h666));
    check("drop_recv_cleared_hdr", 64'(rmt_hdrfc_o), 64'h000066);
    check("drop_recv_cleared_data", 64'(rmt_datafc_o), 64'h000000666);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dll_fc_init.md
DLL_FC_INIT -- requirements
Module: dll_fc_init

Interface
REQ-001 SHALL have parameter RESEND_CYCLES, default 1024: idle cycles between InitFC set retransmissions, range 4..65535.
REQ-002 SHALL have port sclk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port srst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port dlcm_state_i, input, 2: DLCM state; 0 INACTIVE, 1 INIT1, 2 INIT2, 3 ACTIVE.
REQ-005 SHALL have port adv_hdrfc_i, input, 24: local header credits to advertise; [7:0] P, [15:8] NP, [23:16] Cpl.
REQ-006 SHALL have port adv_datafc_i, input, 36: local data credits to advertise; [11:0] P, [23:12] NP, [35:24] Cpl.
REQ-007 SHALL have port dllp_valid_o, output, 1: a DLLP is offered to the DLLP transmit path.
REQ-008 SHALL have port dllp_o, output, 32: offered DLLP body; [31:24] type, [21:14] HdrFC, [11:0] DataFC, all other bits 0.
REQ-009 SHALL have port dllp_ready_i, input, 1: transmit path accepts dllp_o this cycle.
REQ-010 SHALL have port rx_dllp_valid_i, input, 1: a received, CRC-good DLLP is present.
REQ-011 SHALL have port rx_dllp_i, input, 32: received DLLP body, same layout as dllp_o.
REQ-012 SHALL have port init1_end_o, output, 1: FC_INIT1 complete, one-cycle pulse.
REQ-013 SHALL have port init2_end_o, output, 1: FC_INIT2 complete, one-cycle pulse.
REQ-014 SHALL have ports rmt_hdrfc_o (24) and rmt_datafc_o (36), outputs: recorded remote credits, same packing as REQ-005/006.
REQ-015 SHALL have port rmt_fc_valid_o, output, 1: all three remote credit sets recorded (FI1).

Function
REQ-016 SHALL use VC0 only: type codes InitFC1 P/NP/Cpl 0x40/0x50/0x60, InitFC2 0xC0/0xD0/0xE0, UpdateFC 0x80/0x90/0xA0.
REQ-017 SHALL implement FSM IDLE, F1_SEND, F1_WAIT, F1_DONE, F2_SEND, F2_WAIT, DONE.
REQ-018 IDLE: while dlcm_state_i==1, SHALL go to F1_SEND with set index 0 (P).
REQ-019 Each SEND state SHALL send P, NP, Cpl in that order, taking credits from adv_*_i sampled when the DLLP is first offered.
REQ-020 Valid/ready: dllp_o SHALL hold stable while dllp_valid_o=1 and dllp_ready_i=0; transfer on the cycle both are 1; the next DLLP MAY follow the next cycle.
REQ-021 After Cpl transfers, SHALL enter WAIT and clear the timer; on reaching RESEND_CYCLES-1, SHALL return to SEND at index 0.
REQ-022 Receive, in states F1_*: InitFC1 or InitFC2 of type t not yet recorded SHALL store HdrFC/DataFC for t and set recv[t]; an already-recorded type SHALL be ignored.
REQ-023 FI1 (rmt_fc_valid_o) SHALL be set when recv==3'b111; credits SHALL be frozen thereafter until INACTIVE.
REQ-024 SHALL pulse init1_end_o one cycle after FI1 is set at a set boundary (WAIT, or Cpl transferring), then enter F1_DONE.
REQ-025 Mid-set, SHALL complete the current P/NP/Cpl set before pulsing; a set SHALL never be truncated.
REQ-026 F1_DONE SHALL go to F2_SEND, index 0, when dlcm_state_i==2.
REQ-027 In F2_*, receipt of any InitFC2 or UpdateFC SHALL set FI2; InitFC1 SHALL be ignored.
REQ-028 FI2 completion SHALL follow the REQ-024/025 boundary rule: pulse init2_end_o, then enter DONE.
REQ-029 DONE and dlcm_state_i==3 SHALL keep dllp_valid_o=0.
REQ-030 dlcm_state_i==0 in any state SHALL, on the next edge, return to IDLE, drop dllp_valid_o (even mid-handshake), and clear recv, FI1, FI2, timer and rmt_*.
REQ-031 Receive with rx_dllp_valid_i in the same cycle as the set-boundary check SHALL count toward FI1/FI2 in that cycle.
REQ-032 Non-VC0 or unlisted DLLP types SHALL be ignored.
REQ-033 The timer SHALL be 16 bits, saturating, and SHALL NOT wrap.

Reset
REQ-034 srst_n=0 SHALL force IDLE, dllp_valid_o=0, dllp_o=0, init1_end_o=0, init2_end_o=0, rmt_hdrfc_o=0, rmt_datafc_o=0, rmt_fc_valid_o=0, recv=0, timer=0.
REQ-035 After srst_n deasserts, the first dllp_valid_o SHALL occur no earlier than the first edge with dlcm_state_i==1.

Verification
REQ-036 dlcm_state=1, ready=1, adv P=0x20/0x080 -> dllp_o 0x40 then 0x50 then 0x60 on consecutive cycles, P word = 0x40080080.
REQ-037 ready=0 for 5 cycles while P is offered -> dllp_o stable for 5 cycles; transfer on cycle 6.
REQ-038 No receive, RESEND_CYCLES=8 -> sets repeat, with 8 idle cycles between each Cpl transfer and the next P offer.
REQ-039 Rx InitFC1 P, NP, Cpl with NP received twice (0x10 then 0x30), arriving while NP is being offered -> rmt NP hdr=0x10; init1_end_o pulses only after Cpl transfers.
REQ-040 dlcm_state=2, rx UpdateFC-P -> init2_end_o pulses once; then dllp_valid_o stays 0 in state 3.
REQ-041 dlcm_state drops to 0 mid-handshake (valid=1, ready=0) -> dllp_valid_o=0 the next cycle, all rmt_* outputs read 0.
